io_input_port: RTL

Memory-side input responder for the simple 16-bit CPU: supplies the `outside_input` word that the fetch/memory-access stage loads into its MDR during phase 4 when `op_mdr` is set. It synchronizes the board's raw switches and a push button, and debounces the button. Each debounced press captures the switch word into a hold register, raises `input_valid`, and clears it when the CPU consumes the word. Sits between the board I/O pins and the fetch/memory-access stage.

---
 rtl/io_pkg.sv | 11 +
 rtl/key_debouncer.sv | 80 ++++++++
 rtl/io_input_port.sv | 51 +++++
 3 files changed

// File: rtl/io_pkg.sv
// io_pkg: shared debounce state encoding and CPU phase constants for the input port.
package io_pkg;
    typedef enum logic [1:0] {
        RELEASED = 2'd0,
        PRESS_DB = 2'd1,
        PRESSED  = 2'd2,
        REL_DB   = 2'd3
    } db_state_t;

    localparam logic [2:0] PHASE_MEM = 3'b100;
endpackage

// File: rtl/key_debouncer.sv
// key_debouncer: synchronizes the active-low push button and emits one capture pulse per debounced press.
module key_debouncer
    import io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic key_n,
    output logic capture,
    output logic level
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

    logic k1, ks;
    db_state_t state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic done;

    assign done  = cnt == CW'(DEBOUNCE_CYCLES - 1);
    assign level = state == PRESSED || state == REL_DB;

    always_ff @(posedge clock) begin
        if (!reset) begin
            k1    <= 1'b1;
            ks    <= 1'b1;
            state <= RELEASED;
            cnt   <= '0;
        end else begin
            k1    <= key_n;
            ks    <= k1;
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Any opposing sample during a debounce window restarts from zero.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        capture    = 1'b0;
        case (state)
            RELEASED: begin
                if (!ks) begin
                    state_next = PRESS_DB;
                    cnt_next   = '0;
                end
            end
            PRESS_DB: begin
                if (ks) begin
                    state_next = RELEASED;
                    cnt_next   = '0;
                end else if (done) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                    capture    = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (ks) begin
                    state_next = REL_DB;
                    cnt_next   = '0;
                end
            end
            default: begin
                if (!ks) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                end else if (done) begin
                    state_next = RELEASED;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
        endcase
    end
endmodule

// File: rtl/io_input_port.sv
// io_input_port: captures the synchronized switch word on each debounced key press and
// presents it to the CPU's MDR load, tracking valid and overrun status.
module io_input_port
    import io_pkg::*;
#(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_in,
    input  logic             key_n,
    input  logic [2:0]       phase_counter,
    input  logic             op_mdr,
    output logic [WIDTH-1:0] outside_input,
    output logic             input_valid,
    output logic             overrun,
    output logic [WIDTH-1:0] debounced_sw
);
    logic [WIDTH-1:0] sw_s1;
    logic capture, consume, unused_level;

    assign consume = phase_counter == PHASE_MEM && op_mdr;

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
        .clock   (clock),
        .reset   (reset),
        .key_n   (key_n),
        .capture (capture),
        .level   (unused_level)
    );

    // A capture landing on a consume edge hands the CPU the old word and keeps the new one pending.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sw_s1         <= '0;
            debounced_sw  <= '0;
            outside_input <= '0;
            input_valid   <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            sw_s1        <= sw_in;
            debounced_sw <= sw_s1;
            if (capture)
                outside_input <= debounced_sw;
            input_valid <= capture || (input_valid && !consume);
            if (capture && !consume && input_valid)
                overrun <= 1'b1;
        end
    end
endmodule
